// File: rtl/local_bus_slave_if.sv
// Pin-level local bus plus the single-beat register/memory port of local_bus_slave.
// Handshake: the master frames a cycle with nads_i/ncs_i, then each beat is a strobe
// (nwr_i or nrd_i low) acknowledged by exactly one ready_n_o low cycle; bus_wr_o and
// bus_rd_o are one-cycle requests with no back-pressure, and read data returns
// RD_LATENCY cycles after bus_rd_o.
interface local_bus_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NREGIONS   = 4
);
  logic                  nads_i;
  logic                  wnr_i;
  logic [ADDR_WIDTH-1:0] la_i;
  logic [DATA_WIDTH-1:0] ld_i;
  logic [DATA_WIDTH-1:0] ld_o;
  logic                  ld_oe_o;
  logic [NREGIONS-1:0]   ncs_i;
  logic                  nrd_i;
  logic                  nwr_i;
  logic                  ready_n_o;
  logic                  bterm_n_o;
  logic [NREGIONS-1:0]   burst_en_i;
  logic [NREGIONS-1:0]   bus_sel_o;
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic                  bus_wr_o;
  logic [DATA_WIDTH-1:0] bus_wdat_o;
  logic                  bus_rd_o;
  logic [DATA_WIDTH-1:0] bus_rdat_i;
  logic                  timeout_o;
  logic                  timeout_clr_i;
  logic [2:0]            state_dbg;

  modport slave (
    input  nads_i, wnr_i, la_i, ld_i, ncs_i, nrd_i, nwr_i, burst_en_i, bus_rdat_i, timeout_clr_i,
    output ld_o, ld_oe_o, ready_n_o, bterm_n_o, bus_sel_o, bus_addr_o, bus_wr_o, bus_wdat_o,
           bus_rd_o, timeout_o, state_dbg
  );

  modport master (
    output nads_i, wnr_i, la_i, ld_i, ncs_i, nrd_i, nwr_i, burst_en_i, bus_rdat_i, timeout_clr_i,
    input  ld_o, ld_oe_o, ready_n_o, bterm_n_o, bus_sel_o, bus_addr_o, bus_wr_o, bus_wdat_o,
           bus_rd_o, timeout_o, state_dbg
  );
endinterface

// File: rtl/local_bus_slave.sv
// PLX-style local-bus target: turns nADS/nRD/nWR cycles into single-beat register
// port accesses with per-region select, optional bursts capped by BTERM, and a strobe timeout.
module local_bus_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int NREGIONS   = 4,
  parameter int RD_LATENCY = 2,
  parameter int BURST_MAX  = 16,
  parameter int TIMEOUT    = 63
) (
  input logic               clk_i,
  input logic               rst_i,
  local_bus_slave_if.slave  bus
);
  localparam int BEAT_W = $clog2(BURST_MAX) + 1;
  localparam int LAT_W  = $clog2(RD_LATENCY + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_DATA  = 3'd4
  } state_t;

  state_t                state;
  logic                  nads_q, wnr_q, nrd_q, nwr_q;
  logic [ADDR_WIDTH-1:0] la_q, addr_q;
  logic [DATA_WIDTH-1:0] ld_q;
  logic [NREGIONS-1:0]   ncs_q, burst_en_q, sel_q;
  logic                  burst_q;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [LAT_W-1:0]      lat_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  last_beat, end_burst;

  // A beat is terminal when bursting is off, the cap is hit, or the master dropped its select.
  assign last_beat = !burst_q || (beat_cnt == BEAT_W'(BURST_MAX - 1));
  assign end_burst = last_beat || |(sel_q & ncs_q);

  assign bus.bus_sel_o = sel_q;
  assign bus.state_dbg = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      nads_q         <= 1'b1;
      wnr_q          <= 1'b0;
      nrd_q          <= 1'b1;
      nwr_q          <= 1'b1;
      la_q           <= '0;
      ld_q           <= '0;
      ncs_q          <= '1;
      burst_en_q     <= '0;
      addr_q         <= '0;
      sel_q          <= '0;
      burst_q        <= 1'b0;
      beat_cnt       <= '0;
      lat_cnt        <= '0;
      to_cnt         <= '0;
      bus.ld_o       <= '0;
      bus.ld_oe_o    <= 1'b0;
      bus.ready_n_o  <= 1'b1;
      bus.bterm_n_o  <= 1'b1;
      bus.bus_addr_o <= '0;
      bus.bus_wr_o   <= 1'b0;
      bus.bus_wdat_o <= '0;
      bus.bus_rd_o   <= 1'b0;
      bus.timeout_o  <= 1'b0;
    end else begin
      nads_q     <= bus.nads_i;
      wnr_q      <= bus.wnr_i;
      nrd_q      <= bus.nrd_i;
      nwr_q      <= bus.nwr_i;
      la_q       <= bus.la_i;
      ld_q       <= bus.ld_i;
      ncs_q      <= bus.ncs_i;
      burst_en_q <= bus.burst_en_i;

      bus.bus_wr_o  <= 1'b0;
      bus.bus_rd_o  <= 1'b0;
      bus.ready_n_o <= 1'b1;
      bus.bterm_n_o <= 1'b1;
      // A timeout raised in the same cycle as a clear still wins below.
      if (bus.timeout_clr_i) bus.timeout_o <= 1'b0;

      case (state)
        S_IDLE: begin
          beat_cnt    <= '0;
          to_cnt      <= '0;
          bus.ld_oe_o <= 1'b0;
          sel_q       <= '0;
          if (!nads_q && $onehot(~ncs_q)) begin
            sel_q   <= ~ncs_q;
            addr_q  <= la_q;
            burst_q <= |(burst_en_q & ~ncs_q);
            state   <= wnr_q ? S_WR : S_RD_ISSUE;
          end
        end

        S_WR: begin
          if (!nwr_q) begin
            bus.bus_wr_o   <= 1'b1;
            bus.bus_wdat_o <= ld_q;
            bus.bus_addr_o <= addr_q;
            bus.ready_n_o  <= 1'b0;
            bus.bterm_n_o  <= !last_beat;
            addr_q         <= addr_q + ADDR_WIDTH'(1);
            beat_cnt       <= beat_cnt + BEAT_W'(1);
            to_cnt         <= '0;
            if (end_burst) state <= S_IDLE;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            bus.timeout_o <= 1'b1;
            state         <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        S_RD_ISSUE: begin
          bus.bus_rd_o   <= 1'b1;
          bus.bus_addr_o <= addr_q;
          bus.ld_oe_o    <= 1'b1;
          lat_cnt        <= '0;
          state          <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          // lat_cnt is 0 in the cycle bus_rd_o is high, so equality lands on the data cycle.
          if (lat_cnt == LAT_W'(RD_LATENCY)) begin
            bus.ld_o <= bus.bus_rdat_i;
            to_cnt   <= '0;
            state    <= S_RD_DATA;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        S_RD_DATA: begin
          if (!nrd_q) begin
            bus.ready_n_o <= 1'b0;
            bus.bterm_n_o <= !last_beat;
            addr_q        <= addr_q + ADDR_WIDTH'(1);
            beat_cnt      <= beat_cnt + BEAT_W'(1);
            state         <= end_burst ? S_IDLE : S_RD_ISSUE;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            bus.timeout_o <= 1'b1;
            bus.ld_oe_o   <= 1'b0;
            state         <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/local_bus_slave.md
# local_bus_slave

Parametrised successor to the SURF local-bus readout interface. Terminates PLX-style local-bus cycles (nADS, WnR, LA, LD, per-region nCS, nRD/nWR, nREADY, nBTERM) and converts them into a generic single-beat register/memory port with one select line per region. Adds these features:
- any number of chip-select regions;
- per-region runtime burst enable;
- burst length cap enforced with BTERM;
- configurable read-data latency;
- sticky strobe-timeout error.

Sits between the bus pins and the LAB RAM, housekeeping and register banks.

## Interface
Parameters:
- DATA_WIDTH, 32, local data bus and port width
- ADDR_WIDTH, 6, longword address width (LA[7:2] equivalent)
- NREGIONS, 4, number of chip-select regions
- RD_LATENCY, 2, cycles from bus_rd_o to valid bus_rdat_i (≥1)
- BURST_MAX, 16, maximum beats per burst (≥2, power of 2)
- TIMEOUT, 63, idle cycles tolerated waiting for nRD/nWR

Ports:
- clk_i  in  1  sole clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- nads_i  in  1  address strobe, active low
- wnr_i  in  1  1 = write, 0 = read
- la_i  in  ADDR_WIDTH  bus longword address
- ld_i  in  DATA_WIDTH  bus write data
- ld_o  out  DATA_WIDTH  bus read data
- ld_oe_o  out  1  read-data output enable
- ncs_i  in  NREGIONS  region chip selects, active low
- nrd_i, nwr_i  in  1  read/write strobes, active low
- ready_n_o  out  1  beat acknowledge, active low
- bterm_n_o  out  1  burst terminate, active low
- burst_en_i  in  NREGIONS  per-region burst enable
- bus_sel_o  out  NREGIONS  one-hot latched region
- bus_addr_o  out  ADDR_WIDTH  beat address
- bus_wr_o  out  1  one-cycle write strobe
- bus_wdat_o  out  DATA_WIDTH  write data
- bus_rd_o  out  1  one-cycle read request
- bus_rdat_i  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after bus_rd_o
- timeout_o  out  1  sticky strobe-timeout flag
- timeout_clr_i  in  1  clears timeout_o

## Operation
- Every bus input is registered once before use. "Cycle k" refers to the registered copies.
- All outputs are registered.
- Reset values: every output 0, except ready_n_o = 1 and bterm_n_o = 1. rst_i mid-cycle returns to IDLE immediately; no strobe is emitted afterwards.

States:
- IDLE: registered nads low with exactly one ncs low → latch region, address and direction; go to WR (wnr = 1) or RD_ISSUE (wnr = 0). Zero or several ncs low → ignore the strobe and stay in IDLE.
- WR: wait for nwr low. On that cycle:
  - bus_wr_o = 1, bus_wdat_o = ld, bus_addr_o = current address;
  - ready_n_o low for one cycle;
  - address increments, modulo 2^ADDR_WIDTH.
- RD_ISSUE: bus_rd_o = 1 for one cycle. ld_oe_o rises and holds until the read ends.
- RD_WAIT: count RD_LATENCY cycles, then capture bus_rdat_i into ld_o.
- RD_DATA: wait for nrd low, then:
  - ready_n_o low for one cycle;
  - address increments.
- Continuation after a beat: go to IDLE if the region is not burst-enabled, the latched ncs has gone high, or the beat count has reached BURST_MAX. Otherwise go back to WR or RD_ISSUE.
- bterm_n_o is driven low together with ready_n_o on the terminal beat:
  - every beat when burst_en_i[region] = 0;
  - beat BURST_MAX when burst_en_i[region] = 1.
- burst_en_i is sampled when the region is latched in IDLE.
- Timeout: in WR or RD_DATA, TIMEOUT consecutive cycles without the strobe → go to IDLE with no bus strobe, set timeout_o. timeout_o clears on timeout_clr_i; rst_i takes priority over timeout_clr_i.
- ld_oe_o is 0 in IDLE, during writes and after any timeout.
- The beat counter is ceil(log2(BURST_MAX))+1 bits wide and resets to 0 in IDLE.

## Timing
- Address phase: nads registered low at cycle 0 → state change at cycle 1.
- Write beat: nwr registered low at cycle w → bus_wr_o and ready_n_o active during cycle w+1 only.
- Single read: bus_rd_o during cycle 2, ld_o valid at cycle 2+RD_LATENCY+1. ready_n_o follows one cycle after nrd is seen low, and no earlier than that.
- Read burst throughput: one beat per RD_LATENCY+3 cycles.
- Write burst throughput: one beat per cycle while nwr stays low.
- A new nADS during a burst is ignored until the state returns to IDLE.

## Test plan
- Single write, region 1, burst off, la = 0x05, ld = 0xDEADBEEF: one bus_wr_o pulse with bus_sel_o = 0010 and addr 0x05; one ready_n_o low with bterm_n_o low.
- Single read, RD_LATENCY = 2, bus_rdat_i = 0x12345678: ld_o = 0x12345678 and ld_oe_o = 1 when ready_n_o goes low; ld_oe_o = 0 afterwards.
- Write burst, region 0, burst on, nwr held low for 20 beats starting at la = 0x3E: exactly 16 bus_wr_o pulses at addresses 0x3E, 0x3F, 0x00 … 0x0D; bterm_n_o low on the 16th beat only.
- Read burst ended by ncs going high after 3 beats: 3 bus_rd_o pulses at consecutive addresses, no bterm, then back to IDLE.
- nADS with ncs = 1100 (two regions low): no strobes, no ready; the next valid cycle completes normally.
- Write cycle with nwr never asserted: after 63 cycles return to IDLE, timeout_o = 1. Clears on timeout_clr_i. rst_i asserted mid-wait → all outputs at reset values on the next cycle.
